// File: rtl/if_id_buffer_pkg.sv
// Shared pipeline definitions for the fetch/decode boundary.
// Holds the default datapath width, the canonical NOP encoding used wherever
// a stage must present "no instruction", and the IF/ID entry field widths.
package if_id_buffer_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int INSTR_W      = 32;
  localparam int BEST_W       = 1;

  // addi x0, x0, 0
  localparam logic [INSTR_W-1:0] NOP_INSTRUCTION = 32'h0000_0013;

  // Packed width of one IF/ID entry: {pc, pc_plus_4, instruction, branch_estimation}.
  function automatic int entry_width(input int xlen);
    return 2 * xlen + INSTR_W + BEST_W;
  endfunction

endpackage

// File: rtl/if_id_buffer_if.sv
// Fetch/decode handshake bundle.
//   IF_* : fetch side  (valid/ready plus pc, pc_plus_4, instruction, estimate)
//   ID_* : decode side (valid/ready plus the head entry fields)
// modport slave  : the buffer (accepts IF_*, presents ID_*)
// modport master : the surrounding pipeline (drives IF_*, consumes ID_*)
interface if_id_buffer_if
  import if_id_buffer_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) ();

  logic               IF_valid;
  logic               IF_ready;
  logic [XLEN-1:0]    IF_pc;
  logic [XLEN-1:0]    IF_pc_plus_4;
  logic [INSTR_W-1:0] IF_instruction;
  logic               IF_branch_estimation;

  logic               ID_valid;
  logic               ID_ready;
  logic [XLEN-1:0]    ID_pc;
  logic [XLEN-1:0]    ID_pc_plus_4;
  logic [INSTR_W-1:0] ID_instruction;
  logic               ID_branch_estimation;

  modport slave (
    input  IF_valid, IF_pc, IF_pc_plus_4, IF_instruction, IF_branch_estimation, ID_ready,
    output IF_ready, ID_valid, ID_pc, ID_pc_plus_4, ID_instruction, ID_branch_estimation
  );

  modport master (
    output IF_valid, IF_pc, IF_pc_plus_4, IF_instruction, IF_branch_estimation, ID_ready,
    input  IF_ready, ID_valid, ID_pc, ID_pc_plus_4, ID_instruction, ID_branch_estimation
  );

endinterface

// File: rtl/if_id_buffer_sync_fifo_flush.sv
// sync_fifo_flush: generic DEPTH x WIDTH synchronous FIFO.
//   clk, reset   : clock, synchronous active-high reset
//   flush        : synchronous discard of all entries (reset wins over flush)
//   wr_valid/wr_ready/wr_data : write handshake; wr_ready depends only on the
//                               registered count, never on rd_ready
//   rd_valid/rd_ready/rd_data : read handshake; rd_data is the head entry
//   count        : current number of stored entries
module sync_fifo_flush #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  // A full FIFO refuses a write even when a read happens in the same cycle,
  // which keeps wr_ready free of any path from rd_ready.
  assign wr_ready = (count < CW'(DEPTH));
  assign rd_valid = (count != '0);
  assign push     = wr_valid && wr_ready;
  assign pop      = rd_valid && rd_ready;
  assign rd_data  = mem[rd_ptr];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers are AW bits wide and DEPTH is a power of two, so they wrap
      // naturally; count separates full from empty.
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; stale contents are never observable because
  // rd_valid gates them, and leaving it unreset lets it map to plain RAM/flops
  // without a reset tree.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/if_id_buffer.sv
// if_id_buffer: fetch-to-decode pipeline buffer.
// A small in-order FIFO between IF and ID so fetch can run ahead of decode
// stalls without a combinational stall path back to the PC.
//   clk       : clock
//   reset     : synchronous active-high reset (priority over flush)
//   flush     : discard all buffered entries on redirect
//   bus       : if_id_buffer_if.slave, IF_* in, ID_* out (NOP when empty)
//   occupancy : current entry count
module if_id_buffer
  import if_id_buffer_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  if_id_buffer_if.slave          bus,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int WIDTH = entry_width(XLEN);

  logic [WIDTH-1:0]   wr_data;
  logic [WIDTH-1:0]   head;
  logic               head_valid;
  logic [XLEN-1:0]    head_pc;
  logic [XLEN-1:0]    head_pc_plus_4;
  logic [INSTR_W-1:0] head_instruction;
  logic               head_estimation;

  assign wr_data = {bus.IF_pc, bus.IF_pc_plus_4, bus.IF_instruction, bus.IF_branch_estimation};

  sync_fifo_flush #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .wr_valid (bus.IF_valid),
    .wr_ready (bus.IF_ready),
    .wr_data  (wr_data),
    .rd_valid (head_valid),
    .rd_ready (bus.ID_ready),
    .rd_data  (head),
    .count    (occupancy)
  );

  assign {head_pc, head_pc_plus_4, head_instruction, head_estimation} = head;
  assign bus.ID_valid = head_valid;

  // Empty buffer presents a clean NOP bubble so stale storage never leaks
  // into decode.
  // NOTE: every output gets a default first, so no path can leave one
  // unassigned and infer a latch.
  always_comb begin
    bus.ID_pc                = '0;
    bus.ID_pc_plus_4         = '0;
    bus.ID_instruction       = NOP_INSTRUCTION;
    bus.ID_branch_estimation = 1'b0;
    if (head_valid) begin
      bus.ID_pc                = head_pc;
      bus.ID_pc_plus_4         = head_pc_plus_4;
      bus.ID_instruction       = head_instruction;
      bus.ID_branch_estimation = head_estimation;
    end
  end

endmodule

// File: tb/tb_if_id_buffer.sv
// Self-checking bench for if_id_buffer with a queue scoreboard: entries the
// fetch model expects to be accepted are pushed on drive, and the head is
// compared against the DUT every cycle and popped when decode consumes it.
module tb_if_id_buffer;
  import if_id_buffer_pkg::*;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;

  typedef struct {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [31:0]     instr;
    logic            best;
  } entry_t;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  logic [$clog2(DEPTH):0] occupancy;

  if_id_buffer_if #(.XLEN(XLEN)) bus ();

  if_id_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .bus       (bus),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  entry_t sb[$];
  int     n_checks = 0;
  int     n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic logic [31:0] mk_instr(input logic [31:0] pc);
    return 32'h0000_0093 ^ {pc[19:0], 12'h000};
  endfunction

  task automatic check_outputs(input string tag);
    entry_t h;
    logic   v;
    v = (sb.size() != 0);
    if (v) h = sb[0];
    else begin
      h.pc = '0; h.pc4 = '0; h.instr = NOP_INSTRUCTION; h.best = 1'b0;
    end
    check({tag, ".occupancy"}, 64'(occupancy), 64'(sb.size()));
    check({tag, ".IF_ready"},  64'(bus.IF_ready), 64'(sb.size() < DEPTH));
    check({tag, ".ID_valid"},  64'(bus.ID_valid), 64'(v));
    check({tag, ".ID_pc"},     64'(bus.ID_pc), 64'(h.pc));
    check({tag, ".ID_pc4"},    64'(bus.ID_pc_plus_4), 64'(h.pc4));
    check({tag, ".ID_instr"},  64'(bus.ID_instruction), 64'(h.instr));
    check({tag, ".ID_best"},   64'(bus.ID_branch_estimation), 64'(h.best));
  endtask

  // One clock cycle: drive inputs, update the scoreboard at the edge from the
  // pre-edge model state, then compare outputs 1 time unit after the edge.
  task automatic cycle(input string tag, input logic v, input logic [31:0] pc,
                       input logic best, input logic rdy, input logic fl,
                       input logic rst, output logic acc);
    entry_t e;
    entry_t drop;
    logic   pop;
    e.pc = pc; e.pc4 = pc + 32'd4; e.instr = mk_instr(pc); e.best = best;
    bus.IF_valid             = v;
    bus.IF_pc                = e.pc;
    bus.IF_pc_plus_4         = e.pc4;
    bus.IF_instruction       = e.instr;
    bus.IF_branch_estimation = best;
    bus.ID_ready             = rdy;
    flush                    = fl;
    reset                    = rst;
    acc = v && (sb.size() < DEPTH) && !fl && !rst;
    pop = rdy && (sb.size() != 0);
    @(posedge clk);
    if (rst || fl) sb.delete();
    else begin
      if (pop) drop = sb.pop_front();
      if (acc) sb.push_back(e);
    end
    #1;
    check_outputs(tag);
  endtask

  initial begin
    logic acc;
    int   n;
    bus.IF_valid = 1'b0; bus.IF_pc = '0; bus.IF_pc_plus_4 = '0;
    bus.IF_instruction = '0; bus.IF_branch_estimation = 1'b0;
    bus.ID_ready = 1'b0; flush = 1'b0; reset = 1'b1;
    #1;

    // 1. Reset held three cycles, then released.
    for (int i = 0; i < 3; i++) cycle("reset", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
    cycle("post_reset", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, acc);

    // 2. Streaming with decode always ready.
    for (int i = 0; i < 3; i++) cycle("stream", 1'b1, 32'(4 * i), 1'b0, 1'b1, 1'b0, 1'b0, acc);
    cycle("stream_drain", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, acc);

    // 3. Decode stall: fetch holds its PC until accepted.
    n = 0;
    for (int c = 0; c < 12; c++) begin
      cycle("stall", n < 3, 32'h10 + 32'(4 * n), 1'b0, c >= 5, 1'b0, 1'b0, acc);
      if (acc) n++;
    end
    check("stall.accepted", 64'(n), 64'd3);

    // 4. Flush at full together with a push and a pop.
    cycle("fill", 1'b1, 32'h20, 1'b1, 1'b0, 1'b0, 1'b0, acc);
    cycle("fill", 1'b1, 32'h24, 1'b0, 1'b0, 1'b0, 1'b0, acc);
    cycle("flush", 1'b1, 32'h28, 1'b1, 1'b1, 1'b1, 1'b0, acc);
    cycle("post_flush", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, acc);

    // 5. Push and pop together at occupancy 1 across pointer wrap.
    cycle("wrap_prime", 1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0, acc);
    for (int i = 1; i <= 8; i++)
      cycle("wrap", 1'b1, 32'h40 + 32'(4 * i), 1'(i % 2), 1'b1, 1'b0, 1'b0, acc);
    cycle("wrap_drain", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, acc);

    // 6. Reset pulsed mid-stream while fetch is pushing.
    cycle("mid_fill", 1'b1, 32'h60, 1'b1, 1'b0, 1'b0, 1'b0, acc);
    cycle("mid_fill", 1'b1, 32'h64, 1'b0, 1'b0, 1'b0, 1'b0, acc);
    cycle("mid_reset", 1'b1, 32'h68, 1'b1, 1'b0, 1'b0, 1'b1, acc);
    cycle("after_reset", 1'b1, 32'h6c, 1'b1, 1'b0, 1'b0, 1'b0, acc);
    cycle("after_drain", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, acc);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
